instr_fetch_sequencer: RTL and testbench



---
 rtl/tsp_fetch_pkg.sv | 20 ++
 rtl/instr_fetch_sequencer_if.sv | 33 +++
 rtl/fetch_skid_fifo.sv | 53 +++++
 rtl/instr_fetch_sequencer.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tsp_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package tsp_fetch_pkg;

  localparam int FETCH_FIFO_DEPTH  = 2;
  localparam int FETCH_INSTR_WIDTH = 32;
  localparam int FETCH_PC_WIDTH    = 10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_INSTR_WIDTH-1:0] instr;
    logic [FETCH_PC_WIDTH-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Instruction-memory read port plus decoder valid/ready stream.
interface instr_fetch_sequencer_if #(
  parameter int INSTR_WIDTH          = 32,
  parameter int INSTR_MEM_ADDR_WIDTH = 10
);
  logic [INSTR_MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [INSTR_WIDTH-1:0]          mem_instr;
  logic                            mem_instr_valid;
  logic [INSTR_WIDTH-1:0]          dec_instr;
  logic [INSTR_MEM_ADDR_WIDTH-1:0] dec_pc;
  logic                            dec_valid;
  logic                            dec_ready;

  modport master (
    output mem_addr,
    input  mem_instr,
    input  mem_instr_valid,
    output dec_instr,
    output dec_pc,
    output dec_valid,
    input  dec_ready
  );

  modport slave (
    input  mem_addr,
    output mem_instr,
    output mem_instr_valid,
    input  dec_instr,
    input  dec_pc,
    input  dec_valid,
    output dec_ready
  );
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO holding fetched {instr, pc} pairs; flush has priority over push/pop.
module fetch_skid_fifo
  import tsp_fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  entry_t     push_data,
  output entry_t     head,
  output logic       head_valid,
  output logic [1:0] count
);

  entry_t mem [FETCH_FIFO_DEPTH];
  logic   rd_ptr;
  logic   wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (count != 2'd0);

  // Push into a full FIFO is only legal when the head leaves in the same cycle.
  always @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop && count == 2'd2));
      assert (!(pop && count == 2'd0));
    end
  end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// PC sequencer for a 1-cycle-latency instruction memory, streaming words to decode.
// Define FETCH_PERF_CNT_EN to add the pop/stall performance counters.
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | issuing fetches while skid FIFO has room
//   DRAIN | end seen, waiting for FIFO to empty
//   DONE  | one-cycle done pulse
module instr_fetch_sequencer
  import tsp_fetch_pkg::*;
#(
  parameter int INSTR_WIDTH          = 32,
  parameter int INSTR_MEM_ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH           = FETCH_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] start_addr,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            err_overflow,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                     perf_instr_cnt,
  output logic [31:0]                     perf_stall_cnt,
`endif
  instr_fetch_sequencer_if.master         bus
);

  localparam int AW = INSTR_MEM_ADDR_WIDTH;
  localparam logic [AW-1:0] PC_TOP = '1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [AW-1:0]          pc;
  } entry_t;

  generate
    if (FIFO_DEPTH != 2) begin : g_bad_depth
      $error("instr_fetch_sequencer: FIFO_DEPTH must be 2");
    end
  endgenerate

  fetch_state_t  state;
  logic [AW-1:0] pc;
  logic [AW-1:0] issued_pc;
  logic          inflight;
  logic          at_top;
  logic [1:0]    count;
  logic          head_valid;
  entry_t        head;
  entry_t        push_entry;
  logic          pop;
  logic          push;
  logic          issue;
  logic          ret_valid;
  logic          ret_end;
  logic          start_ok;

  assign pop       = head_valid & bus.dec_ready;
  assign start_ok  = (state == IDLE) & start & ~abort;
  assign ret_valid = (state == FETCH) & inflight & bus.mem_instr_valid;
  assign ret_end   = (state == FETCH) & inflight & ~bus.mem_instr_valid;
  assign push      = ret_valid & ~abort;

  // Room check counts the word in flight, which lands in the FIFO this cycle.
  assign issue = (state == FETCH) & ~abort & ~ret_end & ~at_top &
                 ((3'(count) + 3'(inflight) - 3'(pop)) < 3'd2);

  assign push_entry.instr = bus.mem_instr;
  assign push_entry.pc    = issued_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      issued_pc    <= '0;
      inflight     <= 1'b0;
      at_top       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      inflight <= 1'b0;
      at_top   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        issued_pc <= pc;
        if (pc == PC_TOP) at_top <= 1'b1;
        else              pc     <= pc + AW'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            pc           <= start_addr;
            err_overflow <= 1'b0;
            at_top       <= 1'b0;
            busy         <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (ret_end) begin
            state <= DRAIN;
          end else if (ret_valid && at_top) begin
            err_overflow <= 1'b1;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          if (count == 2'd0 && !inflight) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_skid_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (abort),
    .push       (push),
    .pop        (pop),
    .push_data  (push_entry),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign bus.mem_addr  = pc;
  assign bus.dec_instr = head.instr;
  assign bus.dec_pc    = head.pc;
  assign bus.dec_valid = head_valid;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (start_ok) begin
      perf_instr_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop && perf_instr_cnt != '1) perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (head_valid && !bus.dec_ready && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with a 1-cycle-latency ROM model.
module tb_instr_fetch_sequencer;

  localparam int IW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          busy;
  logic          done;
  logic          err_overflow;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_instr_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] rom [1<<AW];
  logic          vld [1<<AW];
  logic [AW-1:0] pop_pc_q[$];
  logic [IW-1:0] pop_instr_q[$];
  int            done_cnt = 0;
  logic          addr0_seen = 1'b0;

  instr_fetch_sequencer_if #(.INSTR_WIDTH(IW), .INSTR_MEM_ADDR_WIDTH(AW)) bus ();

  instr_fetch_sequencer #(
    .INSTR_WIDTH          (IW),
    .INSTR_MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_addr     (start_addr),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .err_overflow   (err_overflow),
`ifdef FETCH_PERF_CNT_EN
    .perf_instr_cnt (perf_instr_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.mem_instr       <= rom[bus.mem_addr];
    bus.mem_instr_valid <= vld[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.dec_valid && bus.dec_ready) begin
        pop_pc_q.push_back(bus.dec_pc);
        pop_instr_q.push_back(bus.dec_instr);
      end
      if (done) done_cnt++;
      if (busy && bus.mem_addr == '0) addr0_seen = 1'b1;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    pop_pc_q.delete();
    pop_instr_q.delete();
    done_cnt   = 0;
    addr0_seen = 1'b0;
  endtask

  task automatic pulse_start(logic [AW-1:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, 64'(n < 200), 64'd1);
  endtask

  task automatic chk_run(string tag, logic [AW-1:0] base, int n);
    chk({tag, "_npop"}, 64'(pop_pc_q.size()), 64'(n));
    for (int i = 0; i < n && i < pop_pc_q.size(); i++) begin
      chk({tag, "_pc"}, 64'(pop_pc_q[i]), 64'(base + AW'(i)));
      chk({tag, "_instr"}, 64'(pop_instr_q[i]), 64'(rom[base + AW'(i)]));
    end
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rdy_pat;
    int n;
    rdy_pat = 4'b1001;
    for (int i = 0; i < (1 << AW); i++) begin
      rom[i] = 32'hC0DE_0000 | 32'(i);
      vld[i] = 1'b0;
    end
    vld[0] = 1'b1; vld[1] = 1'b1; vld[2] = 1'b1;
    vld[10'h3FE] = 1'b1; vld[10'h3FF] = 1'b1;
    bus.dec_ready = 1'b0;

    #2 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_overflow), 64'd0);
    chk("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
    chk("rst_dec_instr", 64'(bus.dec_instr), 64'd0);
    chk("rst_dec_pc", 64'(bus.dec_pc), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);

    // basic run, decoder always ready: words at t+2, t+3, t+4, done during t+6..t+7
    clear_mon();
    bus.dec_ready = 1'b1;
    pulse_start(10'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_mem_addr", 64'(bus.mem_addr), 64'd0);
    tick();
    chk("t1_lat_valid", 64'(bus.dec_valid), 64'd0);
    tick();
    chk("t1_first_valid", 64'(bus.dec_valid), 64'd1);
    chk("t1_first_pc", 64'(bus.dec_pc), 64'd0);
    chk("t1_first_instr", 64'(bus.dec_instr), 64'hC0DE_0000);
    tick();
    chk("t1_pc1", 64'(bus.dec_pc), 64'd1);
    tick();
    chk("t1_pc2", 64'(bus.dec_pc), 64'd2);
    tick();
    chk("t1_drain_valid", 64'(bus.dec_valid), 64'd0);
    chk("t1_drain_done", 64'(done), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd1);
    chk("t1_done_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_done_clr", 64'(done), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk_run("t1", 10'd0, 3);

    // decoder stalled: FIFO fills with pc 0,1 and mem_addr parks at 2
    clear_mon();
    bus.dec_ready = 1'b0;
    pulse_start(10'd0);
    tick(3);
    chk("t2_full_addr_a", 64'(bus.mem_addr), 64'd2);
    chk("t2_full_head", 64'(bus.dec_pc), 64'd0);
    tick();
    chk("t2_full_addr_b", 64'(bus.mem_addr), 64'd2);
    tick();
    chk("t2_full_addr_c", 64'(bus.mem_addr), 64'd2);
    bus.dec_ready = 1'b1;
    tick();
    chk("t2_resume_head", 64'(bus.dec_pc), 64'd1);
    chk("t2_resume_addr", 64'(bus.mem_addr), 64'd3);
    wait_idle("t2");
    chk_run("t2", 10'd0, 3);

    // ready pattern 1,0,0,1 with a stray start while busy
    clear_mon();
    bus.dec_ready = 1'b1;
    pulse_start(10'd0);
    n = 0;
    while (busy && n < 200) begin
      bus.dec_ready = rdy_pat[n % 4];
      if (n == 2) begin
        start      = 1'b1;
        start_addr = 10'h100;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start      = 1'b0;
    start_addr = '0;
    chk("t3_idle_timeout", 64'(n < 200), 64'd1);
    chk_run("t3", 10'd0, 3);

    // run off the top of the address space
    clear_mon();
    bus.dec_ready = 1'b1;
    pulse_start(10'h3FE);
    wait_idle("t4");
    chk_run("t4", 10'h3FE, 2);
    chk("t4_err_ovf", 64'(err_overflow), 64'd1);
    chk("t4_no_wrap", 64'(addr0_seen), 64'd0);

    // start together with abort in IDLE is ignored; sticky error survives
    clear_mon();
    start = 1'b1; abort = 1'b1; start_addr = 10'd0;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_err_kept", 64'(err_overflow), 64'd1);
    tick();
    chk("t5_busy2", 64'(busy), 64'd0);
    chk("t5_dec_valid", 64'(bus.dec_valid), 64'd0);

    // abort one cycle after the first push, decoder stalled
    clear_mon();
    bus.dec_ready = 1'b0;
    pulse_start(10'd0);
    chk("t6_err_clr", 64'(err_overflow), 64'd0);
    tick(2);
    chk("t6_pre_valid", 64'(bus.dec_valid), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_valid", 64'(bus.dec_valid), 64'd0);
    chk("t6_abort_busy", 64'(busy), 64'd0);
    tick(4);
    chk("t6_no_done", 64'(done_cnt), 64'd0);
    bus.dec_ready = 1'b1;
    pulse_start(10'd0);
    wait_idle("t6b");
    chk_run("t6b", 10'd0, 3);

    // asynchronous reset between edges while fetching
    bus.dec_ready = 1'b1;
    pulse_start(10'd0);
    tick(2);
    chk("t7_pre_valid", 64'(bus.dec_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_done", 64'(done), 64'd0);
    chk("t7_dec_valid", 64'(bus.dec_valid), 64'd0);
    chk("t7_dec_pc", 64'(bus.dec_pc), 64'd0);
    chk("t7_dec_instr", 64'(bus.dec_instr), 64'd0);
    chk("t7_mem_addr", 64'(bus.mem_addr), 64'd0);
    tick();
    rst = 1'b0;
    tick();

`ifdef FETCH_PERF_CNT_EN
    chk("p_rst_instr", 64'(perf_instr_cnt), 64'd0);
    chk("p_rst_stall", 64'(perf_stall_cnt), 64'd0);
    clear_mon();
    bus.dec_ready = 1'b0;
    pulse_start(10'd0);
    tick(4);
    bus.dec_ready = 1'b1;
    wait_idle("p");
    tick(2);
    chk_run("p", 10'd0, 3);
    chk("p_instr", 64'(perf_instr_cnt), 64'd3);
    chk("p_stall", 64'(perf_stall_cnt), 64'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
